// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit:
// state encodings, opcode/funct constants, ALU op codes and mux select codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_EXEC_I    = 4'd7,
    ST_ALU_WB    = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_TRAP      = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOT = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALUOP_ADD = 4'b0000;
  localparam logic [3:0] ALUOP_SUB = 4'b0001;
  localparam logic [3:0] ALUOP_SLT = 4'b0010;
  localparam logic [3:0] ALUOP_NOT = 4'b0011;
  localparam logic [3:0] ALUOP_AND = 4'b0100;
  localparam logic [3:0] ALUOP_OR  = 4'b0101;
  localparam logic [3:0] ALUOP_XOR = 4'b0110;
  localparam logic [3:0] ALUOP_SLL = 4'b0111;
  localparam logic [3:0] ALUOP_SRL = 4'b1000;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // States that stall on the memory handshake and are covered by the watchdog.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath (slave).
interface multicycle_control_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  pc_src;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  aluop_selector;
  logic        illegal;
  logic [3:0]  state_out;

  modport master (
    input  instr, zero, mem_ready,
    output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, aluop_selector,
           illegal, state_out
  );

  modport slave (
    output instr, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, aluop_selector,
           illegal, state_out
  );
endinterface

// File: rtl/multicycle_control_alu_control.sv
// Combinational ALU operation select: funct in EXEC_R, opcode in EXEC_I,
// SUB for the beq compare, ADD everywhere else; flags unsupported R-type functs.
module alu_control
  import multicycle_control_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  state_e     state,
  output logic [3:0] aluop_selector,
  output logic       illegal_funct
);

  logic [3:0] r_op_s;
  logic       r_ok_s;
  logic [3:0] i_op_s;

  always_comb begin
    r_op_s = ALUOP_ADD;
    r_ok_s = 1'b1;
    case (funct)
      FN_ADD:  r_op_s = ALUOP_ADD;
      FN_SUB:  r_op_s = ALUOP_SUB;
      FN_SLT:  r_op_s = ALUOP_SLT;
      FN_AND:  r_op_s = ALUOP_AND;
      FN_OR:   r_op_s = ALUOP_OR;
      FN_XOR:  r_op_s = ALUOP_XOR;
      FN_NOT:  r_op_s = ALUOP_NOT;
      FN_SLL:  r_op_s = ALUOP_SLL;
      FN_SRL:  r_op_s = ALUOP_SRL;
      default: r_ok_s = 1'b0;
    endcase
  end

  always_comb begin
    i_op_s = ALUOP_ADD;
    case (opcode)
      OP_ADDI: i_op_s = ALUOP_ADD;
      OP_SLTI: i_op_s = ALUOP_SLT;
      OP_ANDI: i_op_s = ALUOP_AND;
      OP_ORI:  i_op_s = ALUOP_OR;
      OP_XORI: i_op_s = ALUOP_XOR;
      default: i_op_s = ALUOP_ADD;
    endcase
  end

  assign illegal_funct = (opcode == OP_RTYPE) && !r_ok_s;

  always_comb begin
    aluop_selector = ALUOP_ADD;
    case (state)
      ST_EXEC_R: aluop_selector = r_op_s;
      ST_EXEC_I: aluop_selector = i_op_s;
      ST_BRANCH: aluop_selector = ALUOP_SUB;
      default:   aluop_selector = ALUOP_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the MIPS-subset core: state register, memory-wait
// watchdog, reg_dst hold, sticky illegal flag and Moore-style output decode.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam bit              WD_ON    = (MEM_TIMEOUT > 0);

  state_e           state_q, state_d;
  state_e           dispatch_s;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             reg_dst_q, reg_dst_d;
  logic             illegal_q, illegal_d;
  logic [5:0]       opcode_s;
  logic [5:0]       funct_s;
  logic [3:0]       aluop_s;
  logic             illegal_funct_s;
  logic             timeout_s;
  logic             unused_in_s;

  assign opcode_s = bus.instr[31:26];
  assign funct_s  = bus.instr[5:0];
  // Register fields and the zero flag are consumed by the datapath, not here.
  assign unused_in_s = ^{bus.instr[25:6], bus.zero};

  alu_control u_alu_control (
    .opcode         (opcode_s),
    .funct          (funct_s),
    .state          (state_q),
    .aluop_selector (aluop_s),
    .illegal_funct  (illegal_funct_s)
  );

  // Opcode dispatch out of DECODE.
  always_comb begin
    dispatch_s = ST_TRAP;
    case (opcode_s)
      OP_RTYPE: dispatch_s = illegal_funct_s ? ST_TRAP : ST_EXEC_R;
      OP_LW, OP_SW: dispatch_s = ST_MEM_ADDR;
      OP_BEQ:   dispatch_s = ST_BRANCH;
      OP_J:     dispatch_s = ST_JUMP;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: dispatch_s = ST_EXEC_I;
      default:  dispatch_s = ST_TRAP;
    endcase
  end

  // A ready on the last allowed cycle still wins over the watchdog.
  assign timeout_s = WD_ON && (wcnt_q == CNT_LAST) && !bus.mem_ready;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.mem_ready)  state_d = ST_DECODE;
        else if (timeout_s) state_d = ST_TRAP;
        else                state_d = ST_FETCH;
      end
      ST_DECODE:   state_d = dispatch_s;
      ST_MEM_ADDR: state_d = (opcode_s == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ: begin
        if (bus.mem_ready)  state_d = ST_MEM_WB;
        else if (timeout_s) state_d = ST_TRAP;
        else                state_d = ST_MEM_READ;
      end
      ST_MEM_WRITE: begin
        if (bus.mem_ready)  state_d = ST_FETCH;
        else if (timeout_s) state_d = ST_TRAP;
        else                state_d = ST_MEM_WRITE;
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_ALU_WB;
      ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      ST_TRAP:  state_d = ST_TRAP;
      default:  state_d = ST_TRAP;
    endcase
  end

  // Wait counter restarts on every state change and saturates rather than wrapping.
  always_comb begin
    if (state_d != state_q) begin
      wcnt_d = {CNT_W{1'b0}};
    end else if (is_wait_state(state_q) && !bus.mem_ready && (wcnt_q != CNT_MAX)) begin
      wcnt_d = wcnt_q + CNT_W'(1);
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // reg_dst choice made in EXEC is held for the ALU_WB write.
  always_comb begin
    case (state_q)
      ST_EXEC_R: reg_dst_d = 1'b1;
      ST_EXEC_I: reg_dst_d = 1'b0;
      default:   reg_dst_d = reg_dst_q;
    endcase
  end

  assign illegal_d = illegal_q || (state_d == ST_TRAP);

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      wcnt_q    <= {CNT_W{1'b0}};
      reg_dst_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      reg_dst_q <= reg_dst_d;
      illegal_q <= illegal_d;
    end
  end

  // Output decode from the current state; FETCH loads gate on mem_ready.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = PC_SRC_ALU;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRC_B_REG;
    case (state_q)
      ST_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRC_B_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      ST_DECODE:   bus.alu_src_b = SRC_B_IMM_SH2;
      ST_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRC_B_IMM;
      end
      ST_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      ST_EXEC_R: bus.alu_src_a = 1'b1;
      ST_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRC_B_IMM;
      end
      ST_ALU_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = reg_dst_q;
      end
      ST_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = PC_SRC_ALUOUT;
      end
      ST_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PC_SRC_JUMP;
      end
      default: bus.pc_write = 1'b0;
    endcase
  end

  assign bus.aluop_selector = aluop_s;
  assign bus.illegal        = illegal_q;
  assign bus.state_out      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: decode vector table, directed
// multi-cycle corner cases, and random instruction streams against a path model.
module tb_multicycle_control;

  localparam int MEM_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] aluop;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    logic [31:0] instr;
    int          exp_st;
    logic [3:0]  exp_op;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [20];
  logic [5:0] r_fn [9];
  logic [3:0] r_op [9];
  logic [5:0] i_opc [5];
  logic [3:0] i_op [5];
  logic [5:0] bad_opc [4];
  logic [5:0] bad_fn [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ctrl_t sample();
    ctrl_t c;
    c.pc_write      = bus.pc_write;
    c.pc_write_cond = bus.pc_write_cond;
    c.pc_src        = bus.pc_src;
    c.i_or_d        = bus.i_or_d;
    c.mem_read      = bus.mem_read;
    c.mem_write     = bus.mem_write;
    c.ir_write      = bus.ir_write;
    c.reg_write     = bus.reg_write;
    c.reg_dst       = bus.reg_dst;
    c.mem_to_reg    = bus.mem_to_reg;
    c.alu_src_a     = bus.alu_src_a;
    c.alu_src_b     = bus.alu_src_b;
    c.aluop         = bus.aluop_selector;
    c.illegal       = bus.illegal;
    return c;
  endfunction

  // Control word each state must present, straight from the state table.
  function automatic ctrl_t expect_ctrl(input int st, input logic rdy, input logic [3:0] op, input logic rd);
    ctrl_t e = '0;
    case (st)
      0:  begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      1:  e.alu_src_b = 2'b11;
      2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      3:  begin e.mem_read = 1'b1; e.i_or_d = 1'b1; end
      4:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      5:  begin e.mem_write = 1'b1; e.i_or_d = 1'b1; end
      6:  begin e.alu_src_a = 1'b1; e.aluop = op; end
      7:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.aluop = op; end
      8:  begin e.reg_write = 1'b1; e.reg_dst = rd; end
      9:  begin e.alu_src_a = 1'b1; e.aluop = 4'b0001; e.pc_write_cond = 1'b1; e.pc_src = 2'b01; end
      10: begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  // Called at a falling edge; holds reset across one rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(bus.state_out), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] ins, body;
    logic [3:0]  op;
    logic        rd, rdy;
    int          sel, cur, wcnt;
    int          q[$];

    vecs[0]  = '{32'h00221820, 6,  4'd0};
    vecs[1]  = '{32'h00221822, 6,  4'd1};
    vecs[2]  = '{32'h0022182A, 6,  4'd2};
    vecs[3]  = '{32'h00221824, 6,  4'd4};
    vecs[4]  = '{32'h00221825, 6,  4'd5};
    vecs[5]  = '{32'h00221826, 6,  4'd6};
    vecs[6]  = '{32'h00221827, 6,  4'd3};
    vecs[7]  = '{32'h00021880, 6,  4'd7};
    vecs[8]  = '{32'h00021882, 6,  4'd8};
    vecs[9]  = '{32'h0022183F, 11, 4'd0};
    vecs[10] = '{32'h20220005, 7,  4'd0};
    vecs[11] = '{32'h28220005, 7,  4'd2};
    vecs[12] = '{32'h30220005, 7,  4'd4};
    vecs[13] = '{32'h34220005, 7,  4'd5};
    vecs[14] = '{32'h38220005, 7,  4'd6};
    vecs[15] = '{32'h8C220004, 2,  4'd0};
    vecs[16] = '{32'hAC220004, 2,  4'd0};
    vecs[17] = '{32'h10220003, 9,  4'd1};
    vecs[18] = '{32'h08000010, 10, 4'd0};
    vecs[19] = '{32'hFC000000, 11, 4'd0};

    r_fn    = '{6'h20, 6'h22, 6'h2A, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02};
    r_op    = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd3, 4'd7, 4'd8};
    i_opc   = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E};
    i_op    = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6};
    bad_opc = '{6'h3F, 6'h05, 6'h01, 6'h20};
    bad_fn  = '{6'h3F, 6'h08, 6'h21, 6'h03};

    rst_n         = 1'b0;
    bus.instr     = 32'h0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Decode table: state and ALU op two cycles after FETCH.
    for (int i = 0; i < 20; i++) begin
      do_reset();
      bus.instr     = vecs[i].instr;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_state", i), 32'(bus.state_out), 32'(vecs[i].exp_st));
      chk($sformatf("vec%0d_aluop", i), 32'(bus.aluop_selector), 32'(vecs[i].exp_op));
      chk($sformatf("vec%0d_illegal", i), 32'(bus.illegal), 32'(vecs[i].exp_st == 11));
      @(negedge clk);
    end

    // add $3,$1,$2 with memory always ready: 0,1,6,8,0.
    do_reset();
    bus.instr = 32'h00221820; bus.mem_ready = 1'b1;
    #1; chk("add_fetch", 32'(bus.state_out), 32'd0); chk("add_irw", 32'(bus.ir_write), 32'd1);
    @(negedge clk); #1; chk("add_decode", 32'(bus.state_out), 32'd1);
    @(negedge clk); #1; chk("add_exec", 32'(bus.state_out), 32'd6); chk("add_aluop", 32'(bus.aluop_selector), 32'd0);
    @(negedge clk); #1; chk("add_wb", 32'(bus.state_out), 32'd8);
    chk("add_regw", 32'(bus.reg_write), 32'd1); chk("add_regdst", 32'(bus.reg_dst), 32'd1);
    @(negedge clk); #1; chk("add_back", 32'(bus.state_out), 32'd0);

    // lw with three not-ready cycles in MEM_READ.
    bus.instr = 32'h8C220004;
    @(negedge clk); @(negedge clk); #1;
    chk("lw_addr", 32'(bus.state_out), 32'd2);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3);
      #1; chk($sformatf("lw_read%0d", i), 32'(bus.state_out), 32'd3);
      chk($sformatf("lw_mrd%0d", i), 32'(bus.mem_read), 32'd1);
      @(negedge clk);
    end
    #1; chk("lw_wb", 32'(bus.state_out), 32'd4);
    chk("lw_m2r", 32'(bus.mem_to_reg), 32'd1); chk("lw_regw", 32'(bus.reg_write), 32'd1);
    @(negedge clk); #1; chk("lw_back", 32'(bus.state_out), 32'd0);

    // beq taken: 3 cycles FETCH to FETCH.
    bus.instr = 32'h10220003; bus.zero = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("beq_state", 32'(bus.state_out), 32'd9);
    chk("beq_aluop", 32'(bus.aluop_selector), 32'd1);
    chk("beq_pwc", 32'(bus.pc_write_cond), 32'd1);
    chk("beq_pcsrc", 32'(bus.pc_src), 32'd1);
    @(negedge clk); #1; chk("beq_back", 32'(bus.state_out), 32'd0);

    // sw, asynchronous reset between edges in MEM_WRITE.
    bus.instr = 32'hAC220008;
    @(negedge clk); @(negedge clk); @(negedge clk);
    bus.mem_ready = 1'b0;
    #1; chk("sw_state", 32'(bus.state_out), 32'd5); chk("sw_mw", 32'(bus.mem_write), 32'd1);
    #2; rst_n = 1'b0;
    #1; chk("arst_mw", 32'(bus.mem_write), 32'd0); chk("arst_state", 32'(bus.state_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Illegal opcode: DECODE then TRAP, inert for 20 cycles regardless of inputs.
    bus.instr = 32'hFC000000; bus.mem_ready = 1'b1;
    @(negedge clk); #1; chk("bad_decode", 32'(bus.state_out), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("trap_state", 32'(bus.state_out), 32'd11);
      chk("trap_ctrl", 32'(sample()), 32'(expect_ctrl(11, bus.mem_ready, 4'd0, 1'b0)));
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1; chk("trap_rst_state", 32'(bus.state_out), 32'd0); chk("trap_rst_ill", 32'(bus.illegal), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // FETCH watchdog: 16 not-ready cycles trap, ready on the 16th proceeds.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 1; i <= MEM_TIMEOUT; i++) begin
        bus.mem_ready = (pass == 1) && (i == MEM_TIMEOUT);
        #1; chk($sformatf("wd%0d_fetch%0d", pass, i), 32'(bus.state_out), 32'd0);
        @(negedge clk);
      end
      #1; chk($sformatf("wd%0d_after", pass), 32'(bus.state_out), (pass == 0) ? 32'd11 : 32'd1);
      chk($sformatf("wd%0d_ill", pass), 32'(bus.illegal), (pass == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
      do_reset();
    end

    // Random instruction stream against the per-instruction state path model.
    for (int n = 0; n < 200; n++) begin
      sel  = $urandom_range(0, 19);
      body = $urandom;
      op   = 4'd0;
      rd   = 1'b0;
      q.delete();
      q.push_back(0);
      q.push_back(1);
      if (sel < 9) begin
        ins = {6'h00, body[25:6], r_fn[sel]}; op = r_op[sel]; rd = 1'b1;
        q.push_back(6); q.push_back(8);
      end else if (sel < 14) begin
        ins = {i_opc[sel-9], body[25:0]}; op = i_op[sel-9];
        q.push_back(7); q.push_back(8);
      end else if (sel == 14) begin
        ins = {6'h23, body[25:0]}; q.push_back(2); q.push_back(3); q.push_back(4);
      end else if (sel == 15) begin
        ins = {6'h2B, body[25:0]}; q.push_back(2); q.push_back(5);
      end else if (sel == 16) begin
        ins = {6'h04, body[25:0]}; op = 4'd1; q.push_back(9);
      end else if (sel == 17) begin
        ins = {6'h02, body[25:0]}; q.push_back(10);
      end else if (sel == 18) begin
        ins = {bad_opc[body[1:0]], body[25:0]}; q.push_back(11);
      end else begin
        ins = {6'h00, body[25:6], bad_fn[body[31:30]]}; q.push_back(11);
      end
      wcnt = 0;
      while (q.size() > 0) begin
        cur = q[0];
        rdy = ($urandom_range(0, 3) != 0);
        bus.mem_ready = rdy;
        bus.zero      = 1'($urandom_range(0, 1));
        bus.instr     = (cur == 0) ? $urandom : ins;
        #1;
        chk("rnd_state", 32'(bus.state_out), 32'(cur));
        chk("rnd_ctrl", 32'(sample()), 32'(expect_ctrl(cur, rdy, op, rd)));
        if (cur == 11) begin
          q.delete();
          @(negedge clk);
          do_reset();
        end else begin
          if ((cur == 0 || cur == 3 || cur == 5) && !rdy) begin
            wcnt++;
            if (wcnt == MEM_TIMEOUT) begin
              q.delete();
              q.push_back(11);
            end
          end else begin
            void'(q.pop_front());
            wcnt = 0;
          end
          @(negedge clk);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
